result_collector: RTL and testbench

Downstream capture stage for the sorting/ALU datapath. While the datapath asserts Finish it drives one result word per clock onto its tristate Data_out bus; this block samples each word into a local buffer of 2^num_bit_of_column entries. When Finish deasserts, it replays the captured words in order over a valid/ready handshake to the next consumer. It decouples the datapath's unstalled result burst from a consumer that may apply backpressure.

---
 rtl/result_collector.sv | 134 +++++++++++++
 tb/tb_result_collector.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
// Module   : result_collector
// Purpose  : Captures the datapath's unstalled result burst (one word per
//            clock while Finish_in is high) into a local buffer, then replays
//            the words in order over a valid/ready handshake so that a
//            consumer applying backpressure never stalls the datapath.
// Ports    : CLK, RST_n      - clock, asynchronous active-low reset
//            Finish_in      - high = Data_in carries a valid result word
//            Data_in        - datapath result bus (Z/X when Finish_in=0)
//            Out_valid      - Out_data holds a word for the consumer
//            Out_ready      - consumer accepts Out_data this cycle
//            Out_data       - current word, 0 when Out_valid=0
//            Count          - words captured in the current/last burst
//            Busy           - high while capturing or draining
//            Overflow       - sticky, burst exceeded buffer depth
// Revision : 1.0 - initial release
// ============================================================================
module result_collector #(
    parameter int num_bit_of_data   = 8,
    parameter int num_bit_of_column = 4
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         Finish_in,
    input  logic [num_bit_of_data-1:0]   Data_in,
    output logic                         Out_valid,
    input  logic                         Out_ready,
    output logic [num_bit_of_data-1:0]   Out_data,
    output logic [num_bit_of_column:0]   Count,
    output logic                         Busy,
    output logic                         Overflow
);

    localparam int DEPTH = 1 << num_bit_of_column;
    localparam int PW    = num_bit_of_column + 1;

    localparam logic [PW-1:0] c_ONE   = PW'(1);
    localparam logic [PW-1:0] c_DEPTH = PW'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]                 r_state;
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [PW-1:0]              r_count;
    logic                       r_overflow;
    logic [num_bit_of_data-1:0] r_mem [DEPTH];

    logic                         w_room;
    logic                         w_last;
    logic                         w_wr_en;
    logic [num_bit_of_column-1:0] w_wr_addr;

    assign w_room = (r_wr_ptr < c_DEPTH);
    // Count is at least 1 whenever DRAIN is reached, so Count-1 never wraps.
    assign w_last = (r_rd_ptr == (r_count - c_ONE));

    // The first word of a burst is written from IDLE, where wr_ptr is still 0
    // only by convention; force address 0 so a stale pointer cannot leak in.
    // Nothing is written unless Finish_in is high, so a floating bus is never
    // stored.
    assign w_wr_en   = Finish_in &&
                       ((r_state == S_IDLE) || ((r_state == S_CAPTURE) && w_room));
    assign w_wr_addr = (r_state == S_IDLE) ? '0 : r_wr_ptr[num_bit_of_column-1:0];

    // Storage carries no reset; its contents are only presented in DRAIN,
    // which is always preceded by a fresh capture.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= Data_in;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Finish_in) begin
                        r_wr_ptr   <= c_ONE;
                        r_count    <= c_ONE;
                        r_overflow <= 1'b0;
                        r_state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (Finish_in) begin
                        if (w_room) begin
                            r_wr_ptr <= r_wr_ptr + c_ONE;
                            r_count  <= r_count + c_ONE;
                        end else begin
                            // Buffer full: drop the word, Count saturates.
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_rd_ptr <= '0;
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Finish_in is deliberately ignored here.
                    if (Out_ready) begin
                        if (w_last) begin
                            r_state  <= S_IDLE;
                            r_wr_ptr <= '0;
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Out_valid = (r_state == S_DRAIN);
    assign Out_data  = Out_valid ? r_mem[r_rd_ptr[num_bit_of_column-1:0]] : '0;
    assign Count     = r_count;
    assign Busy      = (r_state != S_IDLE);
    assign Overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_collector
// Purpose  : Directed self-checking bench for result_collector. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_result_collector;

    logic       CLK;
    logic       RST_n;
    logic       Finish_in;
    logic [7:0] Data_in;
    logic       Out_valid;
    logic       Out_ready;
    logic [7:0] Out_data;
    logic [4:0] Count;
    logic       Busy;
    logic       Overflow;

    int errors = 0;
    int checks = 0;

    result_collector #(
        .num_bit_of_data   (8),
        .num_bit_of_column (4)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Finish_in (Finish_in),
        .Data_in   (Data_in),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out_data  (Out_data),
        .Count     (Count),
        .Busy      (Busy),
        .Overflow  (Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers only; every comparison lives in the test tasks.
    task automatic capture_word(input logic [7:0] d);
        @(negedge CLK);
        Finish_in = 1'b1;
        Data_in   = d;
    endtask

    task automatic end_burst(input logic rdy);
        @(negedge CLK);
        Finish_in = 1'b0;
        Data_in   = 8'hxx;
        Out_ready = rdy;
    endtask

    task automatic test_reset;
        RST_n = 1'b0; Finish_in = 1'b0; Data_in = 8'h00; Out_ready = 1'b0;
        #12;
        checks++;
        if ({Out_valid, Out_data, Count, Busy, Overflow} !== 16'h0) begin
            errors++;
            $display("FAIL reset_initial: got valid=%b data=%h count=%0d busy=%b ovf=%b, want all 0",
                     Out_valid, Out_data, Count, Busy, Overflow);
        end
        @(negedge CLK); RST_n = 1'b1;
        // Mid-capture asynchronous reset with arbitrary inputs applied.
        capture_word(8'h9C);
        capture_word(8'h3E);
        capture_word(8'h71);
        Out_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b1 || Count !== 5'd3) begin
            errors++;
            $display("FAIL reset_precond: got busy=%b count=%0d, want busy=1 count=3", Busy, Count);
        end
        #2 RST_n = 1'b0;
        #1;
        checks++;
        if ({Out_valid, Out_data, Count, Busy, Overflow} !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b data=%h count=%0d busy=%b ovf=%b, want all 0",
                     Out_valid, Out_data, Count, Busy, Overflow);
        end
        @(negedge CLK);
        Finish_in = 1'b0; Out_ready = 1'b0; RST_n = 1'b1;
    endtask

    task automatic test_basic_burst;
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) capture_word(exp[i]);
        end_burst(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (Out_valid !== 1'b1 || Out_data !== exp[i] || Count !== 5'd4) begin
                errors++;
                $display("FAIL basic_word%0d: got valid=%b data=%h count=%0d, want valid=1 data=%h count=4",
                         i, Out_valid, Out_data, Count, exp[i]);
            end
        end
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Out_valid !== 1'b0 || Out_data !== 8'h00 || Overflow !== 1'b0 || Count !== 5'd4) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b valid=%b data=%h ovf=%b count=%0d, want 0 0 00 0 4",
                     Busy, Out_valid, Out_data, Overflow, Count);
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [4];
        logic       rdy [7];
        int         idx;
        int         hs;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        idx = 0;
        hs  = 0;
        for (int i = 0; i < 4; i++) capture_word(exp[i]);
        end_burst(1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            checks++;
            if (Out_valid !== 1'b1 || idx > 3 || Out_data !== exp[idx > 3 ? 3 : idx]) begin
                errors++;
                $display("FAIL bp_cycle%0d: got valid=%b data=%h, want valid=1 data=%h",
                         c, Out_valid, Out_data, exp[idx > 3 ? 3 : idx]);
            end
            Out_ready = rdy[c];
            if (rdy[c] && Out_valid) begin
                idx++;
                hs++;
            end
        end
        @(negedge CLK);
        checks++;
        if (Out_valid !== 1'b0 || Busy !== 1'b0 || hs != 4) begin
            errors++;
            $display("FAIL bp_end: got valid=%b busy=%b handshakes=%0d, want 0 0 4", Out_valid, Busy, hs);
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 18; i++) capture_word(8'(i));
        end_burst(1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            checks++;
            if (Out_valid !== 1'b1 || Out_data !== 8'(i) || Count !== 5'd16 || Overflow !== 1'b1) begin
                errors++;
                $display("FAIL ovf_word%0d: got valid=%b data=%h count=%0d ovf=%b, want 1 %h 16 1",
                         i, Out_valid, Out_data, Count, Overflow, 8'(i));
            end
        end
        @(negedge CLK);
        checks++;
        if (Out_valid !== 1'b0 || Busy !== 1'b0 || Overflow !== 1'b1 || Count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_idle: got valid=%b busy=%b ovf=%b count=%0d, want 0 0 1 16",
                     Out_valid, Busy, Overflow, Count);
        end
        Finish_in = 1'b1; Data_in = 8'h5A; Out_ready = 1'b0;
        end_burst(1'b1);
        checks++;
        if (Overflow !== 1'b0 || Count !== 5'd1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b count=%0d busy=%b, want 0 1 1", Overflow, Count, Busy);
        end
        @(negedge CLK);
        checks++;
        if (Out_valid !== 1'b1 || Out_data !== 8'h5A) begin
            errors++;
            $display("FAIL ovf_next_word: got valid=%b data=%h, want 1 5a", Out_valid, Out_data);
        end
        @(negedge CLK);
        Out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain;
        capture_word(8'hC1);
        capture_word(8'hC2);
        capture_word(8'hC3);
        capture_word(8'hC4);
        end_burst(1'b1);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (Out_valid !== 1'b1 || Out_data !== 8'hC3) begin
            errors++;
            $display("FAIL rmd_precond: got valid=%b data=%h, want 1 c3", Out_valid, Out_data);
        end
        #1 RST_n = 1'b0;
        #1;
        checks++;
        if ({Out_valid, Out_data, Count, Busy, Overflow} !== 16'h0) begin
            errors++;
            $display("FAIL rmd_reset: got valid=%b data=%h count=%0d busy=%b ovf=%b, want all 0",
                     Out_valid, Out_data, Count, Busy, Overflow);
        end
        @(negedge CLK);
        RST_n = 1'b1; Out_ready = 1'b0;
        capture_word(8'hA5);
        end_burst(1'b1);
        @(negedge CLK);
        checks++;
        if (Out_valid !== 1'b1 || Out_data !== 8'hA5 || Count !== 5'd1) begin
            errors++;
            $display("FAIL rmd_single: got valid=%b data=%h count=%0d, want 1 a5 1", Out_valid, Out_data, Count);
        end
        @(negedge CLK);
        checks++;
        if (Out_valid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL rmd_single_end: got valid=%b busy=%b, want 0 0", Out_valid, Busy);
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] nxt [3];
        nxt = '{8'h31, 8'h32, 8'h33};
        capture_word(8'h01);
        capture_word(8'h02);
        end_burst(1'b0);
        // Stray Finish pulse during DRAIN with the consumer stalled.
        @(negedge CLK);
        Finish_in = 1'b1; Data_in = 8'hFF;
        @(negedge CLK);
        Finish_in = 1'b0; Data_in = 8'hxx;
        checks++;
        if (Out_valid !== 1'b1 || Out_data !== 8'h01 || Count !== 5'd2) begin
            errors++;
            $display("FAIL b2b_ignore: got valid=%b data=%h count=%0d, want 1 01 2", Out_valid, Out_data, Count);
        end
        Out_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (Out_valid !== 1'b1 || Out_data !== 8'h02 || Count !== 5'd2) begin
            errors++;
            $display("FAIL b2b_last: got valid=%b data=%h count=%0d, want 1 02 2", Out_valid, Out_data, Count);
        end
        // New burst begins right after the final handshake edge.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                checks++;
                if (Out_valid !== 1'b0 || Busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: got valid=%b busy=%b, want 0 0", Out_valid, Busy);
                end
            end
            Finish_in = 1'b1; Data_in = nxt[i];
        end
        end_burst(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (Out_valid !== 1'b1 || Out_data !== nxt[i] || Count !== 5'd3) begin
                errors++;
                $display("FAIL b2b_word%0d: got valid=%b data=%h count=%0d, want 1 %h 3",
                         i, Out_valid, Out_data, Count, nxt[i]);
            end
        end
        @(negedge CLK);
        checks++;
        if (Out_valid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got valid=%b busy=%b, want 0 0", Out_valid, Busy);
        end
        Out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_overflow();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
